// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue
// Byte-granular instruction queue between the fetch path and the decoder.
// Accepts 8-byte fetch words and keeps them in order with the head at byte 0.
// Presents a 15-byte window to the decoder.
// Retires byte_incr bytes per decoder consume and advances the instruction pointer.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   fetch_valid/ready fetch word handshake (fetch_ready is registered)
//   fetch_data        8 bytes, byte 0 (lowest address) in bits [7:0]
//   flush, flush_pc   redirect: drop all bytes, load new instruction pointer
//   buffer            window byte i = buffer[i*8 +: 8], byte 0 = queue head
//   window_valid      at least 15 bytes queued
//   consume_en        retire byte_incr bytes (ignored while window_valid=0)
//   byte_incr         bytes to retire, 0..15
//   byte_count        bytes currently queued
//   rip               address of the head byte
//
// DEPTH_BYTES must be a multiple of 8, at least 24 and at most 56, so that
// the count fits the 6-bit byte_count port.
module fetch_byte_queue #(
  parameter int DEPTH_BYTES = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_valid,
  output logic         fetch_ready,
  input  logic [63:0]  fetch_data,
  input  logic         flush,
  input  logic [63:0]  flush_pc,
  output logic [0:119] buffer,
  output logic         window_valid,
  input  logic         consume_en,
  input  logic [3:0]   byte_incr,
  output logic [5:0]   byte_count,
  output logic [63:0]  rip
);

  localparam int         SW          = 8 * DEPTH_BYTES;
  localparam logic [6:0] READY_LIMIT = 7'(DEPTH_BYTES - 8);

  // Storage is kept as one flat vector; byte i lives in mem_r[8*i +: 8].
  // Bytes at index >= count_r are always zero, so a push can be merged
  // into the shifted storage with a plain OR.
  logic [SW-1:0] mem_r;
  logic [SW-1:0] mem_next_s;
  logic [SW-1:0] shifted_s;
  logic [SW-1:0] push_word_s;
  logic [5:0]    count_r;
  logic [5:0]    count_next_s;
  logic [6:0]    count_sum_s;
  logic [5:0]    wr_idx_s;
  logic [63:0]   rip_r;
  logic          ready_r;
  logic          push_s;
  logic          pop_s;
  logic [3:0]    pop_amt_s;
  logic          window_valid_s;

  // Handshake decode, next count and next storage contents.
  always_comb begin
    window_valid_s = (count_r >= 6'd15);
    push_s         = fetch_valid & ready_r;
    pop_s          = consume_en & window_valid_s;
    pop_amt_s      = pop_s ? byte_incr : 4'd0;
    // Carry one extra bit so the ready check sees the true sum.
    count_sum_s    = {1'b0, count_r} + (push_s ? 7'd8 : 7'd0) - {3'b000, pop_amt_s};
    count_next_s   = count_sum_s[5:0];
    // Pushed bytes land right after the bytes that survive the pop.
    wr_idx_s       = count_r - {2'b00, pop_amt_s};
    shifted_s      = mem_r >> {pop_amt_s, 3'b000};
    push_word_s    = {{(SW-64){1'b0}}, fetch_data} << {wr_idx_s, 3'b000};
    if (push_s) begin
      mem_next_s = shifted_s | push_word_s;
    end else begin
      mem_next_s = shifted_s;
    end
  end

  // State registers; flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_r   <= '0;
      count_r <= 6'd0;
      rip_r   <= 64'd0;
      ready_r <= 1'b0;
    end else if (flush) begin
      mem_r   <= '0;
      count_r <= 6'd0;
      rip_r   <= flush_pc;
      ready_r <= 1'b0;
    end else begin
      mem_r   <= mem_next_s;
      count_r <= count_next_s;
      rip_r   <= rip_r + {60'd0, pop_amt_s};
      // A push next cycle must fit even if no bytes are popped.
      ready_r <= (count_sum_s <= READY_LIMIT);
    end
  end

  // Decoder window: head 15 bytes, zero past the queued count.
  always_comb begin
    buffer = '0;
    for (int i = 0; i < 15; i++) begin
      if (i < int'(count_r)) begin
        buffer[i*8 +: 8] = mem_r[i*8 +: 8];
      end else begin
        buffer[i*8 +: 8] = 8'h00;
      end
    end
  end

  assign fetch_ready  = ready_r;
  assign window_valid = window_valid_s;
  assign byte_count   = count_r;
  assign rip          = rip_r;

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Directed testbench for fetch_byte_queue (DEPTH_BYTES = 32).
module tb_fetch_byte_queue;

  logic         clk;
  logic         reset;
  logic         fetch_valid;
  logic         fetch_ready;
  logic [63:0]  fetch_data;
  logic         flush;
  logic [63:0]  flush_pc;
  logic [0:119] buffer;
  logic         window_valid;
  logic         consume_en;
  logic [3:0]   byte_incr;
  logic [5:0]   byte_count;
  logic [63:0]  rip;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] D0 = 64'h0706050403020100;
  localparam logic [63:0] D1 = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] D2 = 64'h1716151413121110;
  localparam logic [63:0] D3 = 64'h1F1E1D1C1B1A1918;
  localparam logic [63:0] D4 = 64'hDEADBEEFCAFEF00D;

  fetch_byte_queue #(.DEPTH_BYTES(32)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .flush(flush), .flush_pc(flush_pc),
    .buffer(buffer), .window_valid(window_valid),
    .consume_en(consume_en), .byte_incr(byte_incr),
    .byte_count(byte_count), .rip(rip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] win(input int i);
    win = buffer[i*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic push_word(input logic [63:0] d);
    fetch_valid = 1'b1;
    fetch_data  = d;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic pop_bytes(input logic [3:0] n);
    consume_en = 1'b1;
    byte_incr  = n;
    tick();
    consume_en = 1'b0;
    byte_incr  = 4'd0;
  endtask

  task automatic test_reset();
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", fetch_ready); end
    checks++; if (byte_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", byte_count); end
    checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b expected 0", window_valid); end
    checks++; if (rip !== 64'd0) begin errors++; $display("FAIL reset_rip: got %h expected 0", rip); end
    checks++; if (buffer !== 120'd0) begin errors++; $display("FAIL reset_buffer: got %h expected 0", buffer); end
    tick();
    reset = 1'b0;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b expected 0", fetch_ready); end
    tick();
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL ready_first_edge: got %b expected 1", fetch_ready); end
  endtask

  task automatic test_push_two();
    push_word(D0);
    checks++; if (byte_count !== 6'd8) begin errors++; $display("FAIL push1_count: got %0d expected 8", byte_count); end
    push_word(D1);
    checks++; if (byte_count !== 6'd16) begin errors++; $display("FAIL push2_count: got %0d expected 16", byte_count); end
    checks++; if (window_valid !== 1'b1) begin errors++; $display("FAIL push2_wvalid: got %b expected 1", window_valid); end
    checks++; if (win(0) !== 8'h00) begin errors++; $display("FAIL push2_byte0: got %h expected 00", win(0)); end
    checks++; if (win(14) !== 8'h0E) begin errors++; $display("FAIL push2_byte14: got %h expected 0e", win(14)); end
    checks++; if (win(9) !== 8'h09) begin errors++; $display("FAIL push2_byte9: got %h expected 09", win(9)); end
    checks++; if (rip !== 64'd0) begin errors++; $display("FAIL push2_rip: got %h expected 0", rip); end
  endtask

  task automatic test_pop();
    pop_bytes(4'd3);
    checks++; if (win(0) !== 8'h03) begin errors++; $display("FAIL pop_head: got %h expected 03", win(0)); end
    checks++; if (byte_count !== 6'd13) begin errors++; $display("FAIL pop_count: got %0d expected 13", byte_count); end
    checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL pop_wvalid: got %b expected 0", window_valid); end
    checks++; if (rip !== 64'd3) begin errors++; $display("FAIL pop_rip: got %h expected 3", rip); end
    checks++; if (win(12) !== 8'h0F) begin errors++; $display("FAIL pop_byte12: got %h expected 0f", win(12)); end
    checks++; if (win(13) !== 8'h00) begin errors++; $display("FAIL pop_byte13_empty: got %h expected 00", win(13)); end
    pop_bytes(4'd5);
    checks++; if (byte_count !== 6'd13) begin errors++; $display("FAIL pop_ignored_count: got %0d expected 13", byte_count); end
    checks++; if (rip !== 64'd3) begin errors++; $display("FAIL pop_ignored_rip: got %h expected 3", rip); end
    checks++; if (win(0) !== 8'h03) begin errors++; $display("FAIL pop_ignored_head: got %h expected 03", win(0)); end
  endtask

  task automatic test_push_pop();
    do_reset();
    push_word(D0);
    push_word(D1);
    fetch_valid = 1'b1;
    fetch_data  = D2;
    consume_en  = 1'b1;
    byte_incr   = 4'd4;
    tick();
    fetch_valid = 1'b0;
    consume_en  = 1'b0;
    byte_incr   = 4'd0;
    checks++; if (byte_count !== 6'd20) begin errors++; $display("FAIL pushpop_count: got %0d expected 20", byte_count); end
    checks++; if (win(0) !== 8'h04) begin errors++; $display("FAIL pushpop_head: got %h expected 04", win(0)); end
    checks++; if (win(12) !== 8'h10) begin errors++; $display("FAIL pushpop_byte12: got %h expected 10", win(12)); end
    checks++; if (win(14) !== 8'h12) begin errors++; $display("FAIL pushpop_byte14: got %h expected 12", win(14)); end
    checks++; if (rip !== 64'd4) begin errors++; $display("FAIL pushpop_rip: got %h expected 4", rip); end
  endtask

  task automatic test_flush();
    flush       = 1'b1;
    flush_pc    = 64'h0000_0000_0040_0000;
    fetch_valid = 1'b1;
    fetch_data  = D3;
    consume_en  = 1'b1;
    byte_incr   = 4'd2;
    tick();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    consume_en  = 1'b0;
    byte_incr   = 4'd0;
    checks++; if (byte_count !== 6'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", byte_count); end
    checks++; if (buffer !== 120'd0) begin errors++; $display("FAIL flush_buffer: got %h expected 0", buffer); end
    checks++; if (rip !== 64'h400000) begin errors++; $display("FAIL flush_rip: got %h expected 400000", rip); end
    checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL flush_wvalid: got %b expected 0", window_valid); end
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_low: got %b expected 0", fetch_ready); end
    tick();
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_high: got %b expected 1", fetch_ready); end
    checks++; if (byte_count !== 6'd0) begin errors++; $display("FAIL flush_after_count: got %0d expected 0", byte_count); end
  endtask

  task automatic test_full();
    do_reset();
    fetch_valid = 1'b1;
    fetch_data  = D0;
    tick();
    fetch_data  = D1;
    tick();
    fetch_data  = D2;
    tick();
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL full_ready_at24: got %b expected 1", fetch_ready); end
    fetch_data  = D3;
    tick();
    checks++; if (byte_count !== 6'd32) begin errors++; $display("FAIL full_count: got %0d expected 32", byte_count); end
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", fetch_ready); end
    fetch_data  = D4;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (byte_count !== 6'd32) begin errors++; $display("FAIL full_hold_count: got %0d expected 32", byte_count); end
      checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready: got %b expected 0", fetch_ready); end
    end
    fetch_valid = 1'b0;
    pop_bytes(4'd15);
    checks++; if (byte_count !== 6'd17) begin errors++; $display("FAIL full_pop1_count: got %0d expected 17", byte_count); end
    checks++; if (win(0) !== 8'h0F) begin errors++; $display("FAIL full_pop1_head: got %h expected 0f", win(0)); end
    checks++; if (win(14) !== 8'h1D) begin errors++; $display("FAIL full_pop1_byte14: got %h expected 1d", win(14)); end
    pop_bytes(4'd15);
    checks++; if (byte_count !== 6'd2) begin errors++; $display("FAIL full_pop2_count: got %0d expected 2", byte_count); end
    checks++; if (win(0) !== 8'h1E) begin errors++; $display("FAIL full_pop2_byte0: got %h expected 1e", win(0)); end
    checks++; if (win(1) !== 8'h1F) begin errors++; $display("FAIL full_pop2_byte1: got %h expected 1f", win(1)); end
    checks++; if (win(2) !== 8'h00) begin errors++; $display("FAIL full_pop2_byte2: got %h expected 00", win(2)); end
    checks++; if (rip !== 64'd30) begin errors++; $display("FAIL full_rip: got %0d expected 30", rip); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_word(D0);
    push_word(D1);
    pop_bytes(4'd4);
    checks++; if (byte_count !== 6'd12) begin errors++; $display("FAIL rmid_pre_count: got %0d expected 12", byte_count); end
    #2;
    reset       = 1'b1;
    fetch_valid = 1'b1;
    fetch_data  = D2;
    #1;
    checks++; if (byte_count !== 6'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", byte_count); end
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b expected 0", fetch_ready); end
    checks++; if (rip !== 64'd0) begin errors++; $display("FAIL rmid_rip: got %h expected 0", rip); end
    checks++; if (buffer !== 120'd0) begin errors++; $display("FAIL rmid_buffer: got %h expected 0", buffer); end
    checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL rmid_wvalid: got %b expected 0", window_valid); end
    tick();
    checks++; if (byte_count !== 6'd0) begin errors++; $display("FAIL rmid_push_dropped: got %0d expected 0", byte_count); end
    checks++; if (buffer !== 120'd0) begin errors++; $display("FAIL rmid_buffer_held: got %h expected 0", buffer); end
    reset       = 1'b0;
    fetch_valid = 1'b0;
    tick();
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_back: got %b expected 1", fetch_ready); end
    checks++; if (byte_count !== 6'd0) begin errors++; $display("FAIL rmid_after_count: got %0d expected 0", byte_count); end
  endtask

  initial begin
    reset       = 1'b1;
    fetch_valid = 1'b0;
    fetch_data  = 64'd0;
    flush       = 1'b0;
    flush_pc    = 64'd0;
    consume_en  = 1'b0;
    byte_incr   = 4'd0;
    #1;
    test_reset();
    test_push_two();
    test_pop();
    test_push_pop();
    test_flush();
    test_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_byte_queue.md
# fetch_byte_queue

Instruction-byte queue that sits between the Sysbus fetch path and the instruction decoder. It accepts 8-byte fetch words, keeps them in order in a byte-granular shift queue, and presents a 15-byte window to the decoder. When the decoder reports the length of the instruction it just parsed through `byte_incr`, the queue retires that many bytes and advances the instruction pointer. It is the supplying end of the decoder's `buffer`/`byte_incr` interface.

## Interface
- `DEPTH_BYTES`, default 32: queue capacity in bytes; must be a multiple of 8 and at least 24.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_valid`  in  1  `fetch_data` holds 8 valid bytes.
- `fetch_ready`  out  1  registered; the queue can take 8 bytes this cycle.
- `fetch_data`  in  64  fetch word; byte k = `fetch_data[8k+7:8k]`, and byte 0 is the lowest address.
- `flush`  in  1  redirect; discard all queued bytes.
- `flush_pc`  in  64  new instruction pointer, loaded on `flush`.
- `buffer`  out  [0:119]  decoder window; window byte i = `buffer[i*8 +: 8]`, and byte 0 is the queue head.
- `window_valid`  out  1  at least 15 bytes are queued.
- `consume_en`  in  1  decoder retires `byte_incr` bytes this cycle.
- `byte_incr`  in  4  number of bytes to retire, 0..15.
- `byte_count`  out  6  number of bytes currently queued.
- `rip`  out  64  address of the head byte.

## Operation
- Storage is `DEPTH_BYTES` byte registers, with the head at index 0, plus a count register.
- Push = `fetch_valid & fetch_ready`.
- Pop = `consume_en & window_valid`, amount `byte_incr`.
  - `consume_en` while `window_valid`=0 is ignored.
  - `byte_incr`=0 retires nothing.
- Next state when there is no flush:
  - Storage shifts toward the head by the pop amount.
  - Pushed bytes are written at index `count - pop`.
  - `count_next = count + 8*push - pop`.
  - `rip_next = rip + pop`, 64-bit, wrapping modulo 2^64.
- Flush has priority over push and pop in the same cycle:
  - `count`, storage and `buffer` go to 0.
  - `rip` loads `flush_pc`.
  - Any push in the flush cycle is dropped.
- `fetch_ready` register is loaded with `(!flush) & (count_next <= DEPTH_BYTES-8)`. A full queue (`count` > `DEPTH_BYTES`-8) deasserts it. Producer data is never lost.
- `buffer` shows the registered storage bytes 0..14. Window bytes at index ≥ `count` read as 8'h00.
- `window_valid` = (`count` >= 15), decoded from the registered count.
- There is no interpretation of instruction bytes; `byte_incr` is trusted.

## Timing
- Reset values:
  - `fetch_ready`=0
  - `buffer`=0
  - `window_valid`=0
  - `byte_count`=0
  - `rip`=0
  - storage=0
- `fetch_ready` first rises on the first edge after `reset` deasserts.
- Reset asserted mid-operation clears everything immediately, asynchronously, and discards any in-flight push or pop.
- Push latency: bytes accepted at edge N are visible in `buffer`/`byte_count` after edge N.
- Pop latency: the window after edge N starts at the old head + `byte_incr`. `rip` updates on the same edge.
- Push and pop in the same cycle are both honoured. The result is exactly the sum defined above.
- Because `fetch_ready` is registered, it reflects the count after the previous edge. Capacity for a push is guaranteed by the `count_next` check.
- Flush latency is one edge:
  - After the flush edge, `byte_count`=0, `window_valid`=0 and `rip`=`flush_pc`.
  - `fetch_ready` is 0 for the cycle after flush and 1 the cycle after that.
- The decoder drives `byte_incr` combinationally from `buffer` within one cycle, which allows back-to-back pops every cycle while `window_valid` holds.

## Test plan
- **Reset, then two pushes.** Release reset and push `0x0706050403020100` then `0x0F0E0D0C0B0A0908`.
  - Expect `byte_count`=16 and `window_valid`=1.
  - Expect `buffer[0:7]`=8'h00, `buffer[112:119]`=8'h0E, and `rip`=0.
- **Pop.** Pop with `consume_en`=1, `byte_incr`=3.
  - Next cycle: head byte 8'h03, `byte_count`=13, `window_valid`=0, `rip`=3.
  - Then `consume_en`=1, `byte_incr`=5 with `window_valid`=0: no change.
- **Simultaneous push and pop.** From 16 bytes, push `0x1716151413121110` while popping 4.
  - Expect `byte_count`=20 and head byte 8'h04.
  - Expect window byte 12 = 8'h10.
- **Full queue.** With `DEPTH_BYTES`=32 and `fetch_valid` held high and no pops:
  - Exactly 4 words are accepted and `byte_count`=32.
  - `fetch_ready`=0 from the edge that made count 32.
  - `fetch_data` changes while `fetch_ready`=0 are not captured.
- **Flush mid-stream.** From 20 bytes, assert `flush` with `flush_pc`=`0x0000_0000_0040_0000`, with a push and a pop in the same cycle.
  - Expect `byte_count`=0, `buffer`=0 and `rip`=`0x400000`.
  - `fetch_ready` is 0 for one cycle, then 1.
- **Reset mid-operation.** Assert `reset` asynchronously between edges with 12 bytes queued.
  - All outputs go to their reset values immediately.
  - A push presented on the next edge while `reset` is still high is dropped.
